// File: rtl/btb_resolve_ctrl.sv
// rtl/btb_resolve_ctrl.sv - BTB prediction queue, branch resolution compare and BTB update/redirect
// Optional saturating statistics counters: define BTB_RESOLVE_STATS_EN.
module btb_resolve_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_push,
  output logic        pred_ready,
  input  logic [31:0] pred_pc,
  input  logic        pred_valid,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        flush,
  output logic        update,
  output logic [31:0] updatePC,
  output logic [31:0] updateTarget,
  output logic        mispredicted,
  output logic        redirect,
`ifdef BTB_RESOLVE_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic [31:0] redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    S_RUN     = 1'b0,
    S_RECOVER = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       pc_mem_d    [DEPTH];
  logic [31:0]       pnext_mem_q [DEPTH];
  logic [31:0]       pnext_mem_d [DEPTH];

  logic              update_q, update_d;
  logic [31:0]       update_pc_q, update_pc_d;
  logic [31:0]       update_target_q, update_target_d;
  logic              mispredicted_q, mispredicted_d;
  logic              redirect_q, redirect_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;

`ifdef BTB_RESOLVE_STATS_EN
  logic [31:0]       stat_branches_q, stat_branches_d;
  logic [31:0]       stat_mispredicts_q, stat_mispredicts_d;
`endif

  logic              full;
  logic              empty;
  logic [PTR_W-1:0]  rd_idx;
  logic [PTR_W-1:0]  wr_idx;
  logic [31:0]       head_pc;
  logic [31:0]       head_pnext;
  logic [31:0]       anext;
  logic [31:0]       pred_pnext;
  logic              mispredict;
  logic              pop;
  logic              push;

  always_comb begin
    rd_idx     = rd_ptr_q[PTR_W-1:0];
    wr_idx     = wr_ptr_q[PTR_W-1:0];
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    pred_ready = !full && (state_q == S_RUN);
    res_ready  = !empty && (state_q == S_RUN);

    // The predicted next PC is folded at push time so only one compare is needed at pop.
    pred_pnext = (pred_valid && pred_taken) ? pred_target : pred_pc + 32'd4;
    head_pc    = pc_mem_q[rd_idx];
    head_pnext = pnext_mem_q[rd_idx];
    anext      = (res_is_branch && res_taken) ? res_target : head_pc + 32'd4;
    mispredict = (head_pnext != anext);

    pop  = res_valid && res_ready && !flush;
    push = pred_push && pred_ready && !flush && !(pop && mispredict);
  end

  always_comb begin
    state_d     = S_RUN;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pc_mem_d    = pc_mem_q;
    pnext_mem_d = pnext_mem_q;

    update_d        = 1'b0;
    update_pc_d     = 32'd0;
    update_target_d = 32'd0;
    mispredicted_d  = 1'b0;
    redirect_d      = 1'b0;
    redirect_pc_d   = 32'd0;

    if (push) begin
      pc_mem_d[wr_idx]    = pred_pc;
      pnext_mem_d[wr_idx] = pred_pnext;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      update_d        = res_is_branch;
      update_pc_d     = head_pc;
      update_target_d = res_target;
      mispredicted_d  = mispredict;
      redirect_d      = mispredict;
      redirect_pc_d   = anext;
      if (mispredict) begin
        // Younger entries were fetched down the wrong path; drop them all.
        rd_ptr_d = wr_ptr_q;
        state_d  = S_RECOVER;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      state_d  = S_RUN;
    end

`ifdef BTB_RESOLVE_STATS_EN
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (update_q && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (update_q && mispredicted_q && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_RUN;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= 32'd0;
        pnext_mem_q[i] <= 32'd0;
      end
      update_q        <= 1'b0;
      update_pc_q     <= 32'd0;
      update_target_q <= 32'd0;
      mispredicted_q  <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= 32'd0;
`ifdef BTB_RESOLVE_STATS_EN
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
`endif
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      pc_mem_q        <= pc_mem_d;
      pnext_mem_q     <= pnext_mem_d;
      update_q        <= update_d;
      update_pc_q     <= update_pc_d;
      update_target_q <= update_target_d;
      mispredicted_q  <= mispredicted_d;
      redirect_q      <= redirect_d;
      redirect_pc_q   <= redirect_pc_d;
`ifdef BTB_RESOLVE_STATS_EN
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
`endif
    end
  end

  assign update       = update_q;
  assign updatePC     = update_pc_q;
  assign updateTarget = update_target_q;
  assign mispredicted = mispredicted_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
`ifdef BTB_RESOLVE_STATS_EN
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
